edge_det_multi: RTL and testbench

//  Multi-channel edge detector and next generation of the single-bit det block. Per channel:
//  - N-flop input synchroniser, then a glitch/debounce filter on the synchronised level.
//  - Rise, fall and any-edge pulses generated from the filtered level.
//  - Per-channel mode selects which edges raise a sticky pending flag; pending flags feed one irq.

---
 rtl/edge_det_multi_pkg.sv | 22 ++
 rtl/edge_det_multi_chan.sv | 112 +++++++++++
 rtl/edge_det_multi.sv | 57 +++++
 tb/tb_edge_det_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_multi_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
// Mode encodings select which filtered edges raise a channel's pending flag.
package edge_det_multi_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = int'(i) + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_det_multi_chan.sv
// One edge-detector channel: synchroniser, persistence filter, edge pulses
// and the sticky pend/ovf flags. pend_nxt is exported so the top can register irq.
module edge_det_chan
    import edge_det_multi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       p_edge,
    output logic       n_edge,
    output logic       d_edge,
    output logic       pend,
    output logic       ovf,
    output logic       pend_nxt
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   level_q;
    logic                   evt;
    logic                   ovf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    generate
        if (FILT_CYC > 0) begin : g_filt
            localparam int FILT_W = (clog2(FILT_CYC + 1) < 1) ? 1 : clog2(FILT_CYC + 1);
            logic [FILT_W-1:0] cnt;

            // Accept a new level only after FILT_CYC consecutive mismatching samples.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (s == level) begin
                    cnt <= '0;
                end else if (cnt == FILT_W'(FILT_CYC - 1)) begin
                    level <= s;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_nofilt
            assign level = s;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign p_edge = level & ~level_q;
    assign n_edge = ~level & level_q;
    assign d_edge = level ^ level_q;

    always_comb begin
        evt = 1'b0;
        case (mode)
            MODE_OFF:  evt = 1'b0;
            MODE_RISE: evt = p_edge;
            MODE_FALL: evt = n_edge;
            MODE_BOTH: evt = p_edge | n_edge;
            default:   evt = 1'b0;
        endcase
    end

    // A same-cycle event beats clr for pend; ovf needs pend already set and no clr.
    always_comb begin
        pend_nxt = pend;
        ovf_nxt  = ovf;
        if (evt) begin
            pend_nxt = 1'b1;
        end else if (clr) begin
            pend_nxt = 1'b0;
        end
        if (evt && pend && !clr) begin
            ovf_nxt = 1'b1;
        end else if (clr) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector top: per-channel slicing of mode/clr,
// one edge_det_chan per channel, and a registered irq from the next-state pend vector.
module edge_det_multi
    import edge_det_multi_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   d,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   p_edge,
    output logic [CH-1:0]   n_edge,
    output logic [CH-1:0]   d_edge,
    output logic [CH-1:0]   pend,
    output logic [CH-1:0]   ovf,
    output logic            irq
);

    logic [CH-1:0] pend_nxt;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            edge_det_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_CYC    (FILT_CYC)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .d        (d[i]),
                .mode     (mode[2*i +: 2]),
                .clr      (clr[i]),
                .level    (level[i]),
                .p_edge   (p_edge[i]),
                .n_edge   (n_edge[i]),
                .d_edge   (d_edge[i]),
                .pend     (pend[i]),
                .ovf      (ovf[i]),
                .pend_nxt (pend_nxt[i])
            );
        end
    endgenerate

    // irq tracks pend's next value so both read 1 in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend_nxt;
        end
    end

endmodule

// File: tb/tb_edge_det_multi.sv
// Bench for edge_det_multi: sample-history model of the main instance checked every
// cycle, plus directed literal checks, and a second FILT_CYC=0 instance.
module tb_edge_det_multi;

    localparam int CH   = 8;
    localparam int SYNC = 2;
    localparam int FILT = 4;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   d;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   level, p_edge, n_edge, d_edge, pend, ovf;
    logic            irq;

    logic [1:0] d_b, clr_b, level_b, p_b, n_b, e_b, pend_b, ovf_b;
    logic [3:0] mode_b;
    logic       irq_b;

    int errors = 0;
    int checks = 0;

    edge_det_multi #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_CYC(FILT)) u_dut (
        .clk(clk), .rst(rst), .d(d), .mode(mode), .clr(clr),
        .level(level), .p_edge(p_edge), .n_edge(n_edge), .d_edge(d_edge),
        .pend(pend), .ovf(ovf), .irq(irq)
    );

    edge_det_multi #(.CH(2), .SYNC_STAGES(2), .FILT_CYC(0)) u_dut_nf (
        .clk(clk), .rst(rst), .d(d_b), .mode(mode_b), .clr(clr_b),
        .level(level_b), .p_edge(p_b), .n_edge(n_b), .d_edge(e_b),
        .pend(pend_b), .ovf(ovf_b), .irq(irq_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: dh[j] holds the d vector sampled j edges ago. The filter input used at
    // an edge is the sample SYNC edges old; level flips once the last FILT such
    // samples all disagree with it.
    logic [CH-1:0] dh [0:SYNC+FILT];
    logic [CH-1:0] m_lvl = '0, m_lq = '0, m_pend = '0, m_ovf = '0;
    logic          m_irq = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [CH-1:0] nl;
        logic          rise, fall, ev, flip;
        if (rst) begin
            for (int j = 0; j <= SYNC + FILT; j++) dh[j] = '0;
            m_lvl = '0; m_lq = '0; m_pend = '0; m_ovf = '0; m_irq = 1'b0;
        end else begin
            for (int j = SYNC + FILT; j > 0; j--) dh[j] = dh[j-1];
            dh[0] = d;
            for (int i = 0; i < CH; i++) begin
                rise = m_lvl[i] && !m_lq[i];
                fall = !m_lvl[i] && m_lq[i];
                ev = (mode[2*i] && rise) || (mode[2*i+1] && fall);
                if (ev) begin
                    if (m_pend[i] && !clr[i]) m_ovf[i] = 1'b1;
                    else if (clr[i]) m_ovf[i] = 1'b0;
                    m_pend[i] = 1'b1;
                end else if (clr[i]) begin
                    m_pend[i] = 1'b0;
                    m_ovf[i] = 1'b0;
                end
            end
            nl = m_lvl;
            for (int i = 0; i < CH; i++) begin
                flip = 1'b1;
                for (int j = SYNC; j < SYNC + FILT; j++)
                    if (dh[j][i] == m_lvl[i]) flip = 1'b0;
                if (flip) nl[i] = ~m_lvl[i];
            end
            m_lq  = m_lvl;
            m_lvl = nl;
            m_irq = |m_pend;
        end
    end

    always @(negedge clk) begin
        chk("m_level",  16'(level),  16'(m_lvl));
        chk("m_p_edge", 16'(p_edge), 16'(m_lvl & ~m_lq));
        chk("m_n_edge", 16'(n_edge), 16'(~m_lvl & m_lq));
        chk("m_d_edge", 16'(d_edge), 16'(m_lvl ^ m_lq));
        chk("m_pend",   16'(pend),   16'(m_pend));
        chk("m_ovf",    16'(ovf),    16'(m_ovf));
        chk("m_irq",    16'(irq),    16'(m_irq));
    end

    initial begin
        rst = 1'b1; d = '0; clr = '0; mode = 16'hFF49;
        d_b = '0; clr_b = '0; mode_b = 4'b1111;

        // Reset state
        tick(3);
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_pend",  16'(pend),  16'h0);
        chk("rst_irq",   16'(irq),   16'h0);
        rst = 1'b0;
        tick(4);

        // 1: rise on ch0, pulse SYNC+FILT edges after drive, then pend/irq
        d[0] = 1'b1;
        tick(5);
        chk("t1_early_p",   16'(p_edge[0]), 16'h0);
        chk("t1_early_lvl", 16'(level[0]),  16'h0);
        tick(1);
        chk("t1_p",      16'(p_edge[0]), 16'h1);
        chk("t1_lvl",    16'(level[0]),  16'h1);
        chk("t1_irq_lo", 16'(irq),       16'h0);
        tick(1);
        chk("t1_p_gone", 16'(p_edge[0]), 16'h0);
        chk("t1_pend",   16'(pend[0]),   16'h1);
        chk("t1_irq",    16'(irq),       16'h1);

        // 2: ch3 3-cycle glitch rejected, 4-cycle pulse accepted
        d[3] = 1'b1; tick(3); d[3] = 1'b0;
        tick(12);
        chk("t2_glitch_lvl",  16'(level[3]), 16'h0);
        chk("t2_glitch_pend", 16'(pend[3]),  16'h0);
        d[3] = 1'b1; tick(4); d[3] = 1'b0;
        tick(2);
        chk("t2_p", 16'(p_edge[3]), 16'h1);
        tick(4);
        chk("t2_n", 16'(n_edge[3]), 16'h1);
        tick(1);
        chk("t2_pend", 16'(pend[3]), 16'h1);

        // 3: ch1 fall-only, ch2 masked
        d[1] = 1'b1; tick(8);
        chk("t3_rise_lvl",  16'(level[1]), 16'h1);
        chk("t3_rise_pend", 16'(pend[1]),  16'h0);
        d[1] = 1'b0; tick(8);
        chk("t3_fall_pend", 16'(pend[1]),  16'h1);
        d[2] = 1'b1; tick(6);
        chk("t3_de_rise", 16'(d_edge[2]), 16'h1);
        tick(2); d[2] = 1'b0; tick(6);
        chk("t3_de_fall", 16'(d_edge[2]), 16'h1);
        tick(2);
        chk("t3_masked_pend", 16'(pend[2]), 16'h0);

        // 4: ovf, clr alone, clr colliding with an event
        clr = '1; tick(1); clr = '0; tick(1);
        chk("t4_clr_all_pend", 16'(pend), 16'h0);
        chk("t4_clr_all_irq",  16'(irq),  16'h0);
        d[5] = 1'b1; tick(8);
        chk("t4_pend",    16'(pend[5]), 16'h1);
        chk("t4_ovf_lo",  16'(ovf[5]),  16'h0);
        d[5] = 1'b0; tick(8);
        chk("t4_ovf",     16'(ovf[5]),  16'h1);
        clr[5] = 1'b1; tick(1); clr = '0;
        chk("t4_clr_pend", 16'(pend[5]), 16'h0);
        chk("t4_clr_ovf",  16'(ovf[5]),  16'h0);
        chk("t4_clr_irq",  16'(irq),     16'h0);
        d[5] = 1'b1; tick(8);
        chk("t4_pend2", 16'(pend[5]), 16'h1);
        d[5] = 1'b0; tick(6);
        chk("t4_n_edge", 16'(n_edge[5]), 16'h1);
        clr[5] = 1'b1; tick(1); clr = '0;
        chk("t4_coll_pend", 16'(pend[5]), 16'h1);
        chk("t4_coll_ovf",  16'(ovf[5]),  16'h0);

        // 5: all channels at once, then reset mid-filter
        mode = '1; d = '0; tick(12);
        clr = '1; tick(1); clr = '0; tick(1);
        d = '1; tick(6);
        chk("t5_p_all", 16'(p_edge), 16'h00FF);
        tick(1);
        chk("t5_pend_all", 16'(pend), 16'h00FF);
        chk("t5_irq",      16'(irq),  16'h1);
        d = '0; tick(3);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_level", 16'(level), 16'h0);
        chk("t5_rst_pend",  16'(pend),  16'h0);
        chk("t5_rst_ovf",   16'(ovf),   16'h0);
        chk("t5_rst_irq",   16'(irq),   16'h0);
        tick(2); rst = 1'b0;
        tick(12);
        chk("t5_post_level", 16'(level), 16'h0);
        chk("t5_post_pend",  16'(pend),  16'h0);

        // 6: unfiltered instance, latency exactly SYNC_STAGES
        d_b[0] = 1'b1; tick(1); d_b[0] = 1'b0;
        chk("t6_p_early", 16'(p_b[0]), 16'h0);
        tick(1);
        chk("t6_p",     16'(p_b[0]),     16'h1);
        chk("t6_lvl",   16'(level_b[0]), 16'h1);
        tick(1);
        chk("t6_n",     16'(n_b[0]),     16'h1);
        chk("t6_lvl0",  16'(level_b[0]), 16'h0);
        chk("t6_pend",  16'(pend_b[0]),  16'h1);
        chk("t6_irq",   16'(irq_b),      16'h1);
        tick(1);
        chk("t6_quiet", 16'({p_b[0], n_b[0]}), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
